// File: rtl/tff_toggle_arbiter_pkg.sv
// Purpose: shared types and defaults for the toggle-slot round-robin arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int GAP_W_DEF = 3;
  localparam int CNT_W_DEF = 8;

  // Width of an index into the requester bank (at least one bit).
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tff_toggle_arbiter_if.sv
// Purpose: request/grant/status bundle between requesters and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: level requests held until granted; grant is a one-cycle pulse.
// Signals: ena/req/gap driven by the requester side (master);
//          gnt/t_q/busy/grant_cnt driven by the arbiter (slave).
interface tff_toggle_arbiter_if
  import tff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             ena;
  logic [N_REQ-1:0] req;
  logic [GAP_W-1:0] gap;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] t_q;
  logic             busy;
  logic [CNT_W-1:0] grant_cnt;

  modport master (
    output ena, req, gap,
    input  gnt, t_q, busy, grant_cnt
  );

  modport slave (
    input  ena, req, gap,
    output gnt, t_q, busy, grant_cnt
  );

endinterface

// File: rtl/tff_toggle_arbiter_rr_pick.sv
// Purpose: combinational round-robin winner search starting just above ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; vld simply reports whether any request is present.
// Ports: req (requests), ptr (last winner) -> vld, win_oh (one-hot), win_idx.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             vld,
  output logic [N_REQ-1:0] win_oh,
  output logic [PTR_W-1:0] win_idx
);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] sel;

  // Requesters strictly above the last winner get first pick; if none of
  // them is asking, the search wraps and the lowest index overall wins.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask[i] = (i > int'(ptr));
    end
  end

  assign hi_req = req & hi_mask;
  assign sel    = (hi_req != '0) ? hi_req : req;
  assign vld    = |req;

  // Descending scan so the lowest set bit of sel is the last one written.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Purpose: round-robin arbiter sharing one toggle slot across a bank of T flip-flops.
// Latency: 1 edge from request to gnt/t_q change; grants spaced 2+gap cycles apart.
// Backpressure: req is level and held until gnt; ena=0 holds off new grants only.
// Ports: clk, rst_n (async active-low); bus (slave): ena, req, gap in;
//        gnt, t_q, busy, grant_cnt out.
module tff_toggle_arbiter
  import tff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int GAP_W = GAP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tff_toggle_arbiter_if.slave  bus
);

  localparam int PTR_W = ptr_width(N_REQ);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] t_q_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pick_vld;
  logic [N_REQ-1:0] pick_oh;
  logic [PTR_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .vld     (pick_vld),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= PTR_W'(N_REQ - 1);  // req[0] wins first after reset
      gap_cnt <= '0;
      gnt_q   <= '0;
      t_q_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ena && pick_vld) begin
            gnt_q   <= pick_oh;
            t_q_q   <= t_q_q ^ pick_oh;  // toggle only the granted bit
            ptr     <= pick_idx;
            cnt_q   <= cnt_q + CNT_W'(1);
            gap_cnt <= bus.gap;          // gap sampled only here
            state   <= GRANT;
          end else begin
            gnt_q <= '0;
          end
        end
        GRANT: begin
          // Requests are ignored: the winner is still dropping its req.
          gnt_q <= '0;
          state <= (gap_cnt != '0) ? GAP : IDLE;
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          gnt_q <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.t_q       = t_q_q;
  assign bus.busy      = (state != IDLE);
  assign bus.grant_cnt = cnt_q;

endmodule
